// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor.
// Sequences the PLL reset and waits for lock with a timeout. It then qualifies
// lock stability before releasing the downstream system reset. A lock loss
// while running re-runs the whole sequence. When every attempt is exhausted,
// the block parks in a sticky FAIL state.
//
// Timed states hold for their entry cycle plus the counted cycles.
// PLLRST leaves once the timer has reached PLL_RST_CYCLES.
// STABLE leaves once the timer has reached LOCK_STABLE with lk still high.
// WAITLOCK gives up on the cycle the timer reaches LOCK_TIMEOUT-1.
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 125000,
   parameter int LOCK_STABLE    = 1024,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       lock_fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_lost_cnt,
   output logic [2:0] state_o
);

   // The shared timer must be able to hold the largest terminal count.
   localparam int MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_COUNT = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
   localparam int TW        = $clog2(MAX_COUNT + 1);

   typedef logic [TW-1:0] timer_t;

   localparam timer_t     RST_DONE     = timer_t'(PLL_RST_CYCLES);
   localparam timer_t     TIMEOUT_LAST = timer_t'(LOCK_TIMEOUT - 1);
   localparam timer_t     STABLE_DONE  = timer_t'(LOCK_STABLE);
   localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLLRST   = 3'd0,
      ST_WAITLOCK = 3'd1,
      ST_STABLE   = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAIL     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   timer_t     timer_q, timer_d;
   logic [1:0] sync_q;
   logic       lk;
   logic [3:0] retry_d;
   logic [7:0] lost_d;

   // Two-flop synchronizer for the asynchronous lock indication.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge refclk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], pll_locked};
   end

   assign lk = sync_q[1];

   // Next-state, timer and counter updates for the supervisor sequence.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + timer_t'(1);
      retry_d = retry_cnt;
      lost_d  = lock_lost_cnt;
      case (state_q)
         ST_PLLRST: begin
            if (timer_q == RST_DONE) begin
               state_d = ST_WAITLOCK;
               timer_d = '0;
            end
         end
         ST_WAITLOCK: begin
            // A lock seen on the timeout cycle still wins.
            if (lk) begin
               state_d = ST_STABLE;
               timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               timer_d = '0;
               if (retry_cnt == RETRY_LIMIT) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_PLLRST;
                  retry_d = retry_cnt + 4'd1;
               end
            end
         end
         ST_STABLE: begin
            // A glitch restarts the lock wait but does not consume a retry.
            if (!lk) begin
               state_d = ST_WAITLOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_DONE) begin
               state_d = ST_RUN;
               timer_d = '0;
            end
         end
         ST_RUN: begin
            timer_d = '0;
            if (!lk) begin
               state_d = ST_PLLRST;
               retry_d = '0;
               if (lock_lost_cnt != 8'hFF) lost_d = lock_lost_cnt + 8'd1;
            end
         end
         ST_FAIL: begin
            timer_d = '0;
         end
         default: begin
            state_d = ST_PLLRST;
            timer_d = '0;
         end
      endcase
   end

   // State register; outputs are decoded from the next state so they are registered.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q       <= ST_PLLRST;
         timer_q       <= '0;
         retry_cnt     <= '0;
         lock_lost_cnt <= '0;
         pll_rst       <= 1'b1;
         sys_rst       <= 1'b1;
         lock_fail     <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         retry_cnt     <= retry_d;
         lock_lost_cnt <= lost_d;
         pll_rst       <= (state_d == ST_PLLRST) || (state_d == ST_FAIL);
         sys_rst       <= (state_d != ST_RUN);
         lock_fail     <= (state_d == ST_FAIL);
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor.
// A cycle-level behavioural model tracks the phase, the edges spent in it and
// the retry and loss counts. Outputs are compared on every falling edge, and
// directed literal checks pin the model's timing.
module tb_pll_lock_supervisor;

   localparam int PRC = 4;
   localparam int LTO = 20;
   localparam int LST = 8;
   localparam int MR  = 2;

   localparam int P_PLLRST = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAIL   = 4;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, lock_fail;
   logic [3:0] retry_cnt;
   logic [7:0] lock_lost_cnt;
   logic [2:0] state_o;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT  (LTO),
      .LOCK_STABLE   (LST),
      .MAX_RETRIES   (MR)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .lock_fail    (lock_fail),
      .retry_cnt    (retry_cnt),
      .lock_lost_cnt(lock_lost_cnt),
      .state_o      (state_o)
   );

   always #5 refclk = ~refclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase   = P_PLLRST;
   int m_dwell   = 0;   // edges spent in the current phase
   int m_retries = 0;
   int m_losses  = 0;
   bit m_s0 = 1'b0, m_s1 = 1'b0, m_lk;
   bit m_valid = 1'b0;

   task enter(input int ph);
      m_phase = ph;
      m_dwell = 0;
   endtask

   always @(posedge refclk) begin
      if (rst) begin
         m_phase   = P_PLLRST;
         m_dwell   = 0;
         m_retries = 0;
         m_losses  = 0;
         m_s0      = 1'b0;
         m_s1      = 1'b0;
         m_valid   = 1'b1;
      end else begin
         m_lk = m_s1;   // lock as seen two edges after the pin
         m_s1 = m_s0;
         m_s0 = pll_locked;
         m_dwell++;
         case (m_phase)
            P_PLLRST: if (m_dwell == PRC + 1) enter(P_WAIT);
            P_WAIT: begin
               if (m_lk) enter(P_STABLE);
               else if (m_dwell == LTO) begin
                  if (m_retries == MR) enter(P_FAIL);
                  else begin
                     m_retries++;
                     enter(P_PLLRST);
                  end
               end
            end
            P_STABLE: begin
               if (!m_lk) enter(P_WAIT);
               else if (m_dwell == LST + 1) enter(P_RUN);
            end
            P_RUN: begin
               if (!m_lk) begin
                  m_losses  = (m_losses < 255) ? m_losses + 1 : 255;
                  m_retries = 0;
                  enter(P_PLLRST);
               end
            end
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge refclk) begin
      if (m_valid) begin
         check("state_o", int'(state_o), m_phase);
         check("pll_rst", int'(pll_rst), int'(m_phase == P_PLLRST || m_phase == P_FAIL));
         check("sys_rst", int'(sys_rst), int'(m_phase != P_RUN));
         check("lock_fail", int'(lock_fail), int'(m_phase == P_FAIL));
         check("retry_cnt", int'(retry_cnt), m_retries);
         check("lock_lost_cnt", int'(lock_lost_cnt), m_losses);
         check("pll_rst_while_sys_released", int'(pll_rst && !sys_rst), 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input logic lock_val);
      pll_locked = lock_val;
      rst = 1'b1;
      repeat (3) @(negedge refclk);
      rst = 1'b0;
   endtask

   task automatic wait_phase(input int ph, input int budget, input string name);
      int found;
      found = 0;
      for (int i = 0; i < budget && found == 0; i++) begin
         @(negedge refclk);
         if (m_phase == ph) found = 1;
      end
      check(name, found, 1);
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] st_log [0:79];
   logic [3:0] rt_log [0:79];
   logic       lf_log [0:79];
   logic       pr_log [0:15];
   logic       sr_log [0:15];

   initial begin
      // Clean lock: pll_locked high from cycle 0.
      do_reset(1'b1);
      for (int e = 0; e < 16; e++) begin
         @(negedge refclk);
         pr_log[e] = pll_rst;
         sr_log[e] = sys_rst;
      end
      check("clean_pll_rst_edge3", int'(pr_log[3]), 1);
      check("clean_pll_rst_edge4", int'(pr_log[4]), 0);
      check("clean_sys_rst_edge13", int'(sr_log[13]), 1);
      check("clean_sys_rst_edge14", int'(sr_log[14]), 0);
      check("clean_retry", int'(retry_cnt), 0);
      check("clean_lock_fail", int'(lock_fail), 0);
      check("clean_state_run", int'(state_o), 3);

      // Loss in RUN: drop seen two edges later, transition on that edge.
      pll_locked = 1'b0;
      @(negedge refclk);
      @(negedge refclk);
      check("loss_sys_rst_before", int'(sys_rst), 0);
      @(negedge refclk);
      check("loss_sys_rst", int'(sys_rst), 1);
      check("loss_state", int'(state_o), 0);
      check("loss_count", int'(lock_lost_cnt), 1);
      check("loss_retry", int'(retry_cnt), 0);
      pll_locked = 1'b1;
      wait_phase(P_RUN, 100, "relock_reaches_run");
      check("relock_sys_rst", int'(sys_rst), 0);

      // Stability glitch: one-cycle drop midway through STABLE.
      do_reset(1'b1);
      wait_phase(P_STABLE, 50, "glitch_reach_stable");
      repeat (3) @(negedge refclk);
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      wait_phase(P_WAIT, 10, "glitch_back_to_wait");
      check("glitch_retry", int'(retry_cnt), 0);
      wait_phase(P_RUN, 50, "glitch_reaches_run");

      // Never lock: three attempts, then FAIL.
      do_reset(1'b0);
      for (int e = 0; e < 80; e++) begin
         @(negedge refclk);
         st_log[e] = 8'(state_o);
         rt_log[e] = retry_cnt;
         lf_log[e] = lock_fail;
      end
      check("never_state_e23", int'(st_log[23]), 1);
      check("never_retry_e23", int'(rt_log[23]), 0);
      check("never_state_e24", int'(st_log[24]), 0);
      check("never_retry_e24", int'(rt_log[24]), 1);
      check("never_state_e73", int'(st_log[73]), 1);
      check("never_retry_e73", int'(rt_log[73]), 2);
      check("never_lock_fail_e73", int'(lf_log[73]), 0);
      check("never_state_e74", int'(st_log[74]), 4);
      check("never_lock_fail_e74", int'(lf_log[74]), 1);
      repeat (200) @(negedge refclk);
      check("fail_held_state", int'(state_o), 4);
      check("fail_held_pll_rst", int'(pll_rst), 1);
      check("fail_held_sys_rst", int'(sys_rst), 1);
      rst = 1'b1;
      @(negedge refclk);
      check("fail_rst_state", int'(state_o), 0);
      check("fail_rst_lock_fail", int'(lock_fail), 0);
      check("fail_rst_pll_rst", int'(pll_rst), 1);
      check("fail_rst_retry", int'(retry_cnt), 0);

      // Saturation: 300 lock losses.
      do_reset(1'b1);
      wait_phase(P_RUN, 50, "sat_first_run");
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         @(negedge refclk);
         pll_locked = 1'b1;
         wait_phase(P_PLLRST, 10, "sat_loss_seen");
         wait_phase(P_RUN, 50, "sat_relock");
      end
      check("sat_lock_lost_cnt", int'(lock_lost_cnt), 255);

      // Reset mid-operation: WAITLOCK with one retry consumed.
      pll_locked = 1'b0;
      begin
         int found;
         found = 0;
         for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge refclk);
            if (m_phase == P_WAIT && m_retries == 1) found = 1;
         end
         check("midrst_reach_wait_retry1", found, 1);
      end
      check("midrst_pre_lost", int'(lock_lost_cnt), 255);
      rst = 1'b1;
      @(negedge refclk);
      check("midrst_state", int'(state_o), 0);
      check("midrst_pll_rst", int'(pll_rst), 1);
      check("midrst_retry", int'(retry_cnt), 0);
      check("midrst_lost", int'(lock_lost_cnt), 0);
      rst = 1'b0;

      // Randomized segments checked by the per-cycle model comparison.
      for (int it = 0; it < 12; it++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         do_reset(1'($urandom_range(0, 1)));
         for (int c = 0; c < 300; c++) begin
            case (mode)
               0: pll_locked = 1'b1;
               1: pll_locked = ($urandom_range(0, 29) != 0);
               2: pll_locked = 1'b0;
               default: pll_locked = 1'($urandom_range(0, 1));
            endcase
            rst = ($urandom_range(0, 499) == 0);
            @(negedge refclk);
         end
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
